// File: rtl/cache_pkg.sv
// Shared geometry and FSM encodings for the data cache controller and its way arrays.
package cache_pkg;
  localparam int SETS        = 64;
  localparam int TAG_W       = 10;
  localparam int ADDR_W      = 19;
  localparam int IDX_W       = $clog2(SETS);
  localparam int LINE_W      = 64;
  localparam int SRAM_ADDR_W = 18;

  // Byte-address field positions: tag = addr[18:9], index = addr[8:3], word = addr[2]
  localparam int WORD_BIT = 2;
  localparam int IDX_LSB  = 3;
  localparam int TAG_LSB  = IDX_LSB + IDX_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bit, tag and 64-bit line; combinational read, clocked write.
module cache_way_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  input  logic              we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line
);
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Only the valid bits are reset; stale tag/data behind a cleared valid is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid_q <= '0;
    else if (we)
      valid_q[index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= wr_tag;
      data_mem[index] <= wr_line;
    end
  end

  assign valid = valid_q[index];
  assign tag   = tag_mem[index];
  assign line  = data_mem[index];
endmodule

// File: rtl/data_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache between MEM stage and SRAM.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module data_cache_controller
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   sram_rd_en,
  output logic                   sram_wr_en,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [LINE_W-1:0]      sram_rdata,
  input  logic                   sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);
  logic [1:0]        state, next_state;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic              word_sel;
  logic              v0, v1;
  logic [TAG_W-1:0]  t0, t1;
  logic [LINE_W-1:0] d0, d1;
  logic              hit0, hit1, hit, hit_way, victim;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word, fill_word;
  logic [SETS-1:0]   lru;
  logic              we0, we1, lru_we, lru_val;
  logic [LINE_W-1:0] wr_line;
  logic              unused_addr_bits;

  assign idx              = addr[TAG_LSB-1:IDX_LSB];
  assign tag_in           = addr[ADDR_W-1:TAG_LSB];
  assign word_sel         = addr[WORD_BIT];
  assign unused_addr_bits = ^{addr[31:ADDR_W], addr[WORD_BIT-1:0]};
  assign sram_wdata       = wdata;

  cache_way_array u_way0 (
    .clk(clk), .rst(rst), .index(idx), .we(we0), .wr_tag(tag_in), .wr_line(wr_line),
    .valid(v0), .tag(t0), .line(d0)
  );

  cache_way_array u_way1 (
    .clk(clk), .rst(rst), .index(idx), .we(we1), .wr_tag(tag_in), .wr_line(wr_line),
    .valid(v1), .tag(t1), .line(d1)
  );

  assign hit0      = v0 && (t0 == tag_in);
  assign hit1      = v1 && (t1 == tag_in);
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign hit_line  = hit1 ? d1 : d0;
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
  // Fill an empty way first; only fall back to LRU when both ways hold data.
  assign victim    = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx]);

  always_comb begin
    next_state = state;
    ready      = 1'b1;
    rdata      = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    sram_addr  = '0;
    we0        = 1'b0;
    we1        = 1'b0;
    wr_line    = sram_rdata;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_en) begin
          ready      = 1'b0;
          next_state = ST_WRITE;
        end else if (rd_en) begin
          if (hit) begin
            rdata   = hit_word;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            ready      = 1'b0;
            next_state = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        sram_rd_en = 1'b1;
        sram_addr  = {addr[ADDR_W-1:IDX_LSB], 2'b00};
        ready      = sram_ready;
        if (sram_ready) begin
          we0        = ~victim;
          we1        = victim;
          lru_we     = 1'b1;
          lru_val    = ~victim;
          rdata      = fill_word;
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: begin
        sram_wr_en = 1'b1;
        sram_addr  = {addr[ADDR_W-1:WORD_BIT], 1'b0};
        ready      = sram_ready;
        if (sram_ready) begin
          // Write-through: only a line already present is updated, nothing is allocated.
          if (hit) begin
            wr_line = word_sel ? {wdata, hit_line[31:0]} : {hit_line[63:32], wdata};
            we0     = ~hit_way;
            we1     = hit_way;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lru <= '0;
    else if (lru_we)
      lru[idx] <= lru_val;
  end

`ifdef CACHE_STATS_EN
  logic hit_acc, miss_acc;

  assign hit_acc  = (state == ST_IDLE) && rd_en && !wr_en && hit;
  assign miss_acc = (state == ST_IDLE) && rd_en && !wr_en && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (miss_acc && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_cache_controller.sv
// Table-driven bench for data_cache_controller with a queue scoreboard and a small SRAM responder.
// Covers the CACHE_STATS_EN counters when that macro is defined.
module tb_data_cache_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready, sram_rd_en, sram_wr_en;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] line;
    logic        exp_sram;
    logic [17:0] exp_saddr;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic        exp_sram;
    logic [17:0] exp_saddr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  data_cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request, answer SRAM two cycles after it is requested, compare when ready rises.
  task automatic access(input vec_t v);
    exp_t e;
    logic seen, seen_wr, done;
    logic [17:0] saddr;
    int cyc, waited;
    e.is_wr = v.is_wr; e.exp_sram = v.exp_sram; e.exp_saddr = v.exp_saddr;
    e.exp_rdata = v.exp_rdata; e.exp_wdata = v.wdata;
    sb.push_back(e);
    if (!v.is_wr) begin
      if (v.exp_sram) exp_miss++;
      else exp_hits++;
    end
    @(negedge clk);
    rd_en = !v.is_wr; wr_en = v.is_wr; addr = v.addr; wdata = v.wdata;
    sram_rdata = v.line; sram_ready = 1'b0;
    seen = 1'b0; seen_wr = 1'b0; saddr = '0; done = 1'b0; cyc = 0; waited = 0;
    while (!done && cyc < 40) begin
      #1;
      check("sram_en_exclusive", sram_rd_en & sram_wr_en, 1'b0);
      if ((sram_rd_en || sram_wr_en) && !seen) begin
        seen = 1'b1; seen_wr = sram_wr_en; saddr = sram_addr;
      end
      sram_ready = seen && (sram_rd_en || sram_wr_en) && (waited >= 2);
      if (seen) waited++;
      #1;
      if (ready) begin
        done = 1'b1;
        e = sb.pop_front();
        check("sram_access", seen, e.exp_sram);
        if (e.exp_sram) begin
          check("sram_addr", saddr, e.exp_saddr);
          check("sram_is_write", seen_wr, e.is_wr);
        end
        if (e.is_wr) check("sram_wdata", sram_wdata, e.exp_wdata);
        else         check("rdata", rdata, e.exp_rdata);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("ready_seen", done, 1'b1);
    if (!done) e = sb.pop_front();
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int cyc;
    vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0, 64'h11112222_33334444, 1'b1, 18'h004, 32'h3333_4444};
    vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0, 64'h0,                 1'b0, 18'h000, 32'h1111_2222};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0, 64'hAAAA0001_AAAA0000, 1'b1, 18'h000, 32'hAAAA_0000};
    vecs[3]  = '{1'b0, 32'h0000_0200, 32'h0, 64'hBBBB0001_BBBB0000, 1'b1, 18'h100, 32'hBBBB_0000};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0, 64'h0,                 1'b0, 18'h000, 32'hAAAA_0000};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0, 64'hCCCC0001_CCCC0000, 1'b1, 18'h200, 32'hCCCC_0000};
    vecs[6]  = '{1'b0, 32'hFFF8_0000, 32'h0, 64'h0,                 1'b0, 18'h000, 32'hAAAA_0000};
    vecs[7]  = '{1'b0, 32'h0000_0204, 32'h0, 64'hBBBB0003_BBBB0002, 1'b1, 18'h100, 32'hBBBB_0003};
    vecs[8]  = '{1'b1, 32'h0000_0008, 32'hDEADBEEF, 64'h0,          1'b1, 18'h004, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0, 64'h0,                 1'b0, 18'h000, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 32'h0000_000C, 32'h0, 64'h0,                 1'b0, 18'h000, 32'h1111_2222};
    vecs[11] = '{1'b1, 32'h0000_1000, 32'h0BADF00D, 64'h0,          1'b1, 18'h800, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_1000, 32'h0, 64'hDDDD0001_DDDD0000, 1'b1, 18'h800, 32'hDDDD_0000};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0;
    #1;
    check("reset_ready", ready, 1'b1);
    check("reset_rdata", rdata, 32'h0);
    check("reset_sram_rd_en", sram_rd_en, 1'b0);
    check("reset_sram_wr_en", sram_wr_en, 1'b0);
    check("reset_sram_addr", sram_addr, 18'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) access(vecs[i]);

`ifdef CACHE_STATS_EN
    #1;
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_miss);
`endif

    // Reset while a fill is waiting on SRAM.
    @(negedge clk);
    rd_en = 1'b1; addr = 32'h0000_0040; sram_ready = 1'b0; sram_rdata = 64'h0;
    #1;
    cyc = 0;
    while (!sram_rd_en && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("abort_fill_entered", sram_rd_en, 1'b1);
    check("abort_fill_addr", sram_addr, 18'h020);
    rd_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    exp_hits = 0; exp_miss = 0;
    check("abort_sram_rd_en", sram_rd_en, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle_rd_en", sram_rd_en, 1'b0);
    check("abort_idle_wr_en", sram_wr_en, 1'b0);

    v = '{1'b0, 32'h0000_0008, 32'h0, 64'h55556666_77778888, 1'b1, 18'h004, 32'h7777_8888};
    access(v);
    v = '{1'b0, 32'h0000_000C, 32'h0, 64'h0, 1'b0, 18'h000, 32'h5555_6666};
    access(v);

`ifdef CACHE_STATS_EN
    #1;
    check("hit_count_after_rst", hit_count, exp_hits);
    check("miss_count_after_rst", miss_count, exp_miss);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
